vga_char_disp: RTL and testbench

VGA_CHAR_DISP -- requirements
Module: vga_char_disp

---
 rtl/vga_pkg.sv | 46 ++++
 rtl/char_rom.sv | 30 +++
 rtl/vga_char_disp.sv | 140 ++++++++++++++
 tb/tb_vga_char_disp.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Constants and helpers shared by the VGA character display blocks.
// axis_step advances one origin coordinate of the bouncing glyph by a single move.
package vga_pkg;

  localparam int H_VALID = 640;
  localparam int V_VALID = 480;
  localparam logic [9:0] PIX_INVALID = 10'h3FF;

  localparam logic [15:0] BLACK  = 16'h0000;
  localparam logic [15:0] WHITE  = 16'hFFFF;
  localparam logic [15:0] GOLDEN = 16'hFEC0;

  // fwd = 1 means the origin is moving towards larger coordinates
  typedef struct packed {
    logic [9:0] org;
    logic       fwd;
  } axis_t;

  // Clamp-and-reverse on both edges; 11-bit math keeps org + step + size from wrapping
  function automatic axis_t axis_step(input axis_t cur, input logic [10:0] step,
                                      input logic [10:0] size, input logic [10:0] limit);
    axis_t       nxt;
    logic [10:0] org_w;
    org_w = {1'b0, cur.org};
    nxt   = cur;
    if (cur.fwd) begin
      if (org_w + step + size > limit) begin
        nxt.org = 10'(limit - size);
        nxt.fwd = 1'b0;
      end else begin
        nxt.org = 10'(org_w + step);
        nxt.fwd = 1'b1;
      end
    end else begin
      if (org_w < step) begin
        nxt.org = 10'd0;
        nxt.fwd = 1'b1;
      end else begin
        nxt.org = 10'(org_w - step);
        nxt.fwd = 1'b0;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/char_rom.sv
// Glyph bitmap ROM with a one-cycle registered read; bit CHAR_W-1 is the leftmost pixel.
// The bitmap is a fixed checkerboard, so a glyph pixel is lit when column and row parities differ.
module char_rom #(
  parameter int CHAR_W = 256
) (
  input  logic              vga_clk,
  input  logic              sys_rst_n,
  input  logic [6:0]        addr,
  output logic [CHAR_W-1:0] data
);

  function automatic logic [CHAR_W-1:0] glyph_row(input logic [6:0] row);
    logic [CHAR_W-1:0] bits;
    bits = {CHAR_W{1'b0}};
    for (int col = 0; col < CHAR_W; col++) begin
      bits[CHAR_W-1-col] = col[0] ^ row[0];
    end
    return bits;
  endfunction

  // Registered row read
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      data <= {CHAR_W{1'b0}};
    end else begin
      data <= glyph_row(addr);
    end
  end

endmodule

// File: rtl/vga_char_disp.sv
// Renders one scaled glyph over a background colour with static, bounce and blink modes.
// Two-stage pipeline: window/ROM address, then glyph bit select and the registered pixel.
module vga_char_disp
  import vga_pkg::*;
#(
  parameter int CHAR_W       = 256,
  parameter int CHAR_H       = 88,
  parameter int CHAR_B_H     = 192,
  parameter int CHAR_B_V     = 208,
  parameter int SCALE_SHIFT  = 0,
  parameter int STEP         = 2,
  parameter int MOVE_DIV     = 1,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic [1:0]  mode,
  input  logic [15:0] fg_color,
  input  logic [15:0] bg_color,
  output logic [15:0] pix_data
);

  localparam logic [10:0] W_SC       = 11'(CHAR_W << SCALE_SHIFT);
  localparam logic [10:0] H_SC       = 11'(CHAR_H << SCALE_SHIFT);
  localparam logic [10:0] STEP_W     = 11'(STEP);
  localparam logic [10:0] H_LIM      = 11'(H_VALID);
  localparam logic [10:0] V_LIM      = 11'(V_VALID);
  localparam logic [7:0]  MOVE_LAST  = 8'(MOVE_DIV - 1);
  localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam axis_t       X_HOME     = {10'(CHAR_B_H), 1'b1};
  localparam axis_t       Y_HOME     = {10'(CHAR_B_V), 1'b1};

  if ((CHAR_W << SCALE_SHIFT) > H_VALID || (CHAR_H << SCALE_SHIFT) > V_VALID) begin : g_size_check
    $error("vga_char_disp: scaled glyph does not fit the visible area");
  end

  axis_t             ax_r, ay_r, ax_nxt_s, ay_nxt_s;
  logic [1:0]        mode_r;
  logic              visible_r;
  logic [7:0]        frame_cnt_r, blink_cnt_r;
  logic              coord_ok_s, in_x_s, in_y_s, in_win_s, frame_tick_s;
  logic [10:0]       dx_s, dy_s;
  logic [7:0]        lx_s;
  logic [6:0]        ly_s;
  logic              vld1_r, in_win1_r, vis1_r;
  logic [7:0]        lx1_r;
  logic [CHAR_W-1:0] rom_data_s;
  logic [255:0]      rom_row_s;
  logic              glyph_bit_s;

  // Stage 0: window test, glyph-local coordinates and frame tick
  always_comb begin
    coord_ok_s   = (pix_x != PIX_INVALID) && (pix_y != PIX_INVALID);
    in_x_s       = ({1'b0, pix_x} >= {1'b0, ax_r.org}) && ({1'b0, pix_x} < {1'b0, ax_r.org} + W_SC);
    in_y_s       = ({1'b0, pix_y} >= {1'b0, ay_r.org}) && ({1'b0, pix_y} < {1'b0, ay_r.org} + H_SC);
    in_win_s     = coord_ok_s && in_x_s && in_y_s;
    dx_s         = {1'b0, pix_x} - {1'b0, ax_r.org};
    dy_s         = {1'b0, pix_y} - {1'b0, ay_r.org};
    lx_s         = 8'(dx_s >> SCALE_SHIFT);
    ly_s         = 7'(dy_s >> SCALE_SHIFT);
    frame_tick_s = (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));
    ax_nxt_s     = axis_step(ax_r, STEP_W, W_SC, H_LIM);
    ay_nxt_s     = axis_step(ay_r, STEP_W, H_SC, V_LIM);
  end

  char_rom #(.CHAR_W(CHAR_W)) u_rom (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .addr      (ly_s),
    .data      (rom_data_s)
  );

  // Out-of-window lx may index past a narrow glyph; in_win1_r masks that bit
  always_comb begin
    rom_row_s   = 256'(rom_data_s);
    glyph_bit_s = rom_row_s[8'(CHAR_W - 1) - lx1_r];
  end

  // Pixel pipeline; stage 2 emits black until a real coordinate has propagated
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld1_r    <= 1'b0;
      in_win1_r <= 1'b0;
      vis1_r    <= 1'b0;
      lx1_r     <= 8'd0;
      pix_data  <= BLACK;
    end else begin
      vld1_r    <= 1'b1;
      in_win1_r <= in_win_s;
      vis1_r    <= visible_r;
      lx1_r     <= lx_s;
      if (!vld1_r) begin
        pix_data <= BLACK;
      end else if (in_win1_r && vis1_r && glyph_bit_s) begin
        pix_data <= fg_color;
      end else begin
        pix_data <= bg_color;
      end
    end
  end

  // Per-frame state; decisions use the mode latched at the previous frame tick
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ax_r        <= X_HOME;
      ay_r        <= Y_HOME;
      mode_r      <= 2'b00;
      visible_r   <= 1'b1;
      frame_cnt_r <= 8'd0;
      blink_cnt_r <= 8'd0;
    end else if (frame_tick_s) begin
      mode_r <= mode;
      if (!mode_r[0]) begin
        ax_r        <= X_HOME;
        ay_r        <= Y_HOME;
        frame_cnt_r <= 8'd0;
      end else if (frame_cnt_r == MOVE_LAST) begin
        ax_r        <= ax_nxt_s;
        ay_r        <= ay_nxt_s;
        frame_cnt_r <= 8'd0;
      end else begin
        frame_cnt_r <= frame_cnt_r + 8'd1;
      end
      if (!mode_r[1]) begin
        visible_r   <= 1'b1;
        blink_cnt_r <= 8'd0;
      end else if (blink_cnt_r == BLINK_LAST) begin
        visible_r   <= ~visible_r;
        blink_cnt_r <= 8'd0;
      end else begin
        blink_cnt_r <= blink_cnt_r + 8'd1;
      end
    end else begin
      mode_r <= mode_r;
    end
  end

endmodule

// File: tb/tb_vga_char_disp.sv
// Directed bench for vga_char_disp: three instances (default, 2x scaled, odd-size corner bouncer)
// driven with shared coordinates; glyph is a checkerboard lit where lx and ly parities differ.
module tb_vga_char_disp;
  import vga_pkg::*;

  logic        vga_clk = 1'b0;
  logic        sys_rst_n;
  logic [9:0]  pix_x, pix_y;
  logic [1:0]  mode;
  logic [15:0] fg_color, bg_color;
  logic [15:0] pd_main, pd_scl, pd_cnr;
  int          total = 0;
  int          bad   = 0;

  always #5 vga_clk = ~vga_clk;

  vga_char_disp #(.BLINK_FRAMES(2)) dut_main (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_x(pix_x), .pix_y(pix_y), .mode(mode),
    .fg_color(fg_color), .bg_color(bg_color), .pix_data(pd_main));

  vga_char_disp #(.CHAR_W(128), .SCALE_SHIFT(1)) dut_scl (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_x(pix_x), .pix_y(pix_y), .mode(mode),
    .fg_color(fg_color), .bg_color(bg_color), .pix_data(pd_scl));

  vga_char_disp #(.CHAR_W(255), .CHAR_H(127), .CHAR_B_H(385), .CHAR_B_V(321)) dut_cnr (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_x(pix_x), .pix_y(pix_y), .mode(mode),
    .fg_color(fg_color), .bg_color(bg_color), .pix_data(pd_cnr));

  typedef struct { int x; int y; bit fx; bit fy; } org_m;
  typedef struct { int x; int y; bit main_fg; bit scl_fg; } vec_t;

  org_m     m_main, m_cnr;
  bit [1:0] mq_m;
  vec_t     vecs[17];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pd_of(input int idx);
    case (idx)
      0:       return pd_main;
      1:       return pd_scl;
      default: return pd_cnr;
    endcase
  endfunction

  function automatic org_m move(input org_m o, input int w, input int h);
    org_m n = o;
    if (o.fx) begin
      if (o.x + 2 + w > 640) begin n.x = 640 - w; n.fx = 1'b0; end
      else n.x = o.x + 2;
    end else begin
      if (o.x < 2) begin n.x = 0; n.fx = 1'b1; end
      else n.x = o.x - 2;
    end
    if (o.fy) begin
      if (o.y + 2 + h > 480) begin n.y = 480 - h; n.fy = 1'b0; end
      else n.y = o.y + 2;
    end else begin
      if (o.y < 2) begin n.y = 0; n.fy = 1'b1; end
      else n.y = o.y - 2;
    end
    return n;
  endfunction

  task automatic probe(input int idx, input int x, input int y, input bit exp_fg, input string name);
    pix_x = 10'(x);
    pix_y = 10'(y);
    repeat (2) @(posedge vga_clk);
    #1;
    check(name, pd_of(idx), exp_fg ? fg_color : bg_color);
    pix_x = PIX_INVALID;
    pix_y = PIX_INVALID;
  endtask

  // Origin is pinned by lit pixels at (X, Y+1) and (X+1, Y) with unlit neighbours just outside
  task automatic probe_origin(input int idx, input int x, input int y, input string name);
    probe(idx, x, y + 1, 1'b1, {name, "_in_left"});
    if (x > 0) probe(idx, x - 1, y + 1, 1'b0, {name, "_out_left"});
    probe(idx, x + 1, y, 1'b1, {name, "_in_top"});
    if (y > 0) probe(idx, x + 1, y - 1, 1'b0, {name, "_out_top"});
  endtask

  task automatic tick();
    pix_x = 10'd639;
    pix_y = 10'd479;
    @(posedge vga_clk);
    #1;
    pix_x = PIX_INVALID;
    pix_y = PIX_INVALID;
    if (mq_m[0]) begin
      m_main = move(m_main, 256, 88);
      m_cnr  = move(m_cnr, 255, 127);
    end else begin
      m_main = '{192, 208, 1'b1, 1'b1};
      m_cnr  = '{385, 321, 1'b1, 1'b1};
    end
    mq_m = mode;
  endtask

  initial begin
    vecs[0]  = '{192,  209, 1'b1, 1'b0};
    vecs[1]  = '{191,  209, 1'b0, 1'b0};
    vecs[2]  = '{448,  208, 1'b0, 1'b0};
    vecs[3]  = '{192,  296, 1'b0, 1'b0};
    vecs[4]  = '{447,  208, 1'b1, 1'b1};
    vecs[5]  = '{192,  208, 1'b0, 1'b0};
    vecs[6]  = '{193,  208, 1'b1, 1'b0};
    vecs[7]  = '{194,  208, 1'b0, 1'b1};
    vecs[8]  = '{192,  210, 1'b0, 1'b1};
    vecs[9]  = '{447,  295, 1'b0, 1'b0};
    vecs[10] = '{446,  295, 1'b1, 1'b0};
    vecs[11] = '{300,  250, 1'b0, 1'b1};
    vecs[12] = '{192,  383, 1'b0, 1'b1};
    vecs[13] = '{192,  384, 1'b0, 1'b0};
    vecs[14] = '{1023, 209, 1'b0, 1'b0};
    vecs[15] = '{192, 1023, 1'b0, 1'b0};
    vecs[16] = '{0,      0, 1'b0, 1'b0};

    m_main    = '{192, 208, 1'b1, 1'b1};
    m_cnr     = '{385, 321, 1'b1, 1'b1};
    mq_m      = 2'b00;
    sys_rst_n = 1'b0;
    pix_x     = PIX_INVALID;
    pix_y     = PIX_INVALID;
    mode      = 2'b00;
    fg_color  = GOLDEN;
    bg_color  = WHITE;

    repeat (3) @(posedge vga_clk);
    #1;
    check("reset_main", pd_main, BLACK);
    check("reset_scl", pd_scl, BLACK);
    check("reset_cnr", pd_cnr, BLACK);
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(posedge vga_clk);
    #1;

    // Static mode window and glyph mapping, unscaled and 2x scaled
    for (int i = 0; i < 17; i++) begin
      pix_x = 10'(vecs[i].x);
      pix_y = 10'(vecs[i].y);
      repeat (2) @(posedge vga_clk);
      #1;
      check($sformatf("vec%0d_main", i), pd_main, vecs[i].main_fg ? fg_color : bg_color);
      check($sformatf("vec%0d_scl", i), pd_scl, vecs[i].scl_fg ? fg_color : bg_color);
    end
    pix_x = PIX_INVALID;
    pix_y = PIX_INVALID;

    // Bounce: right-edge clamp and reversal on the default instance
    mode = 2'b01;
    tick();
    for (int i = 0; i < 300 && m_main.x != 382; i++) tick();
    probe_origin(0, 382, m_main.y, "b382");
    tick();
    probe_origin(0, 384, m_main.y, "b384_fwd");
    tick();
    probe_origin(0, 384, m_main.y, "b384_rev");
    tick();
    probe_origin(0, 382, m_main.y, "b382_back");

    // Bounce: simultaneous left/top corner hit on the odd-size instance
    for (int i = 0; i < 400 && !(m_cnr.x == 1 && !m_cnr.fx); i++) tick();
    probe_origin(2, 1, 1, "c11");
    tick();
    probe_origin(2, 0, 0, "c00");
    tick();
    probe_origin(2, 2, 2, "c22");

    // Blink with BLINK_FRAMES = 2, then a mid-frame return to static
    mode = 2'b00;
    tick();
    tick();
    mode = 2'b10;
    for (int f = 0; f < 4; f++) begin
      tick();
      probe(0, 192, 209, f < 2, $sformatf("blink_f%0d", f));
    end
    mode = 2'b00;
    probe(0, 192, 209, 1'b0, "switch_mid_frame");
    for (int f = 0; f < 3; f++) begin
      tick();
      probe(0, 192, 209, 1'b1, $sformatf("static_f%0d", f));
    end

    // Reset pulse mid-frame on a lit scaled pixel
    pix_x = 10'd300;
    pix_y = 10'd250;
    @(posedge vga_clk);
    #1;
    sys_rst_n = 1'b0;
    @(posedge vga_clk);
    #1;
    check("rst_pulse_scl", pd_scl, BLACK);
    check("rst_pulse_main", pd_main, BLACK);
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
    repeat (3) @(posedge vga_clk);
    #1;
    check("post_rst_scl", pd_scl, fg_color);
    check("post_rst_main", pd_main, bg_color);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
